// File: rtl/frame_store_ctrl.sv
// Still-frame BRAM owner: quantises one live frame to RGB332 on capture, then replays it.
// All outputs registered one cycle after the pixel they refer to; no backpressure (pixel-clock paced).
module frame_store_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 400,
  parameter int ADDR_W   = 18
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              capture_i,
  input  logic              store_bram_i,
  input  logic [10:0]       hcount_i,
  input  logic [9:0]        vcount_i,
  input  logic [23:0]       pixel_rgb_i,
  output logic [1:0]        bram_state_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic              bram_we_o,
  output logic [7:0]        bram_din_o,
  output logic              frame_done_o
);

  typedef enum logic [1:0] {
    IDLE          = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } state_e;

  localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        din_q, din_d;
  logic              done_q, done_d;

  logic       in_disp;
  logic       sof;
  logic       last_pix;
  logic [7:0] rgb332;
  logic       unused_rgb_bits;

  assign in_disp  = (hcount_i < H_LIM) && (vcount_i < V_LIM);
  assign sof      = (hcount_i == 11'd0) && (vcount_i == 10'd0);
  assign last_pix = (wr_cnt_q == LAST_ADDR);
  assign rgb332   = {pixel_rgb_i[23:21], pixel_rgb_i[15:13], pixel_rgb_i[7:6]};
  assign unused_rgb_bits = ^{pixel_rgb_i[20:16], pixel_rgb_i[12:8], pixel_rgb_i[5:0]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (capture_i) state_d = CAPTURE_FRAME;
      CAPTURE_FRAME: if (sof) state_d = WRITING_FRAME;
      WRITING_FRAME: begin
        if (in_disp && last_pix) state_d = store_bram_i ? READING_FRAME : IDLE;
      end
      READING_FRAME: begin
        if (capture_i)          state_d = CAPTURE_FRAME;
        else if (!store_bram_i) state_d = IDLE;
      end
      default:       state_d = IDLE;
    endcase
  end

  // Next values of the registered BRAM-side outputs and the write/read counters.
  always_comb begin
    we_d     = 1'b0;
    done_d   = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (capture_i) wr_cnt_d = '0;
      end
      CAPTURE_FRAME: begin
        if (sof) begin
          we_d     = 1'b1;
          addr_d   = wr_cnt_q;
          din_d    = rgb332;
          wr_cnt_d = wr_cnt_q + ADDR_ONE;
        end
      end
      WRITING_FRAME: begin
        if (in_disp) begin
          we_d   = 1'b1;
          addr_d = wr_cnt_q;
          din_d  = rgb332;
          if (last_pix) begin
            done_d   = 1'b1;
            rd_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_ONE;
          end
        end
      end
      READING_FRAME: begin
        // Running raster index replaces hcount + vcount*H_ACTIVE.
        if (sof) begin
          addr_d   = '0;
          rd_cnt_d = ADDR_ONE;
        end else if (in_disp) begin
          addr_d   = rd_cnt_q;
          rd_cnt_d = rd_cnt_q + ADDR_ONE;
        end
        if (capture_i) wr_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      we_q     <= we_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bram_state_o = state_q;
  assign bram_addr_o  = addr_q;
  assign bram_we_o    = we_q;
  assign bram_din_o   = din_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_frame_store_ctrl.sv
// Directed bench for frame_store_ctrl; frame height shortened so whole frames stay cheap.
module tb_frame_store_ctrl;
  localparam int H  = 640;
  localparam int V  = 4;
  localparam int AW = 18;
  localparam int HT = 648;
  localparam int VT = 6;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture;
  logic          store_bram;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [23:0]   pixel_rgb;
  logic [1:0]    bram_state;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [7:0]    bram_din;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_store_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .capture_i    (capture),
    .store_bram_i (store_bram),
    .hcount_i     (hcount),
    .vcount_i     (vcount),
    .pixel_rgb_i  (pixel_rgb),
    .bram_state_o (bram_state),
    .bram_addr_o  (bram_addr),
    .bram_we_o    (bram_we),
    .bram_din_o   (bram_din),
    .frame_done_o (frame_done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [23:0] rgb, input logic cap);
    hcount    = 11'(h);
    vcount    = 10'(v);
    pixel_rgb = rgb;
    capture   = cap;
    step();
    capture   = 1'b0;
  endtask

  function automatic logic [23:0] pix(input int h, input int v);
    return {8'(h), 8'(v * 37 + 11), 8'(h ^ (v << 3))};
  endfunction

  function automatic logic [7:0] q332(input logic [23:0] c);
    return {c[23:21], c[15:13], c[7:6]};
  endfunction

  // Entered in CAPTURE_FRAME; drives one raster frame starting at sof.
  task automatic write_frame(input logic store_mid);
    int idx = 0, we_cnt = 0, done_cnt = 0, bad = 0;
    int last_we_addr = -1, done_addr = -1;
    store_bram = 1'b1;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        logic [23:0] c;
        logic disp;
        c    = (h == 5 && v == 0) ? 24'hE0A0C0 : pix(h, v);
        disp = (h < H) && (v < V);
        if (v == 2 && h == 0) store_bram = store_mid;
        drive(h, v, c, (h == 100 && v == 1));
        if (bram_we === 1'b1) begin
          we_cnt++;
          last_we_addr = int'(bram_addr);
        end
        if (frame_done === 1'b1) begin
          done_cnt++;
          done_addr = int'(bram_addr);
        end
        if (disp) begin
          if (bram_we !== 1'b1 || bram_addr !== AW'(idx) || bram_din !== q332(c) ||
              frame_done !== (idx == N - 1)) bad++;
          idx++;
        end else if (bram_we !== 1'b0 || frame_done !== 1'b0) begin
          bad++;
        end
        if (h == 5 && v == 0) begin
          chk("rgb332_din", bram_din, 8'hF7);
          chk("rgb332_addr", bram_addr, 5);
        end
        if (h == 100 && v == 1) chk("capture_ignored_writing", bram_state, 2'b10);
        if (h == 645 && v == 1) chk("blank_h_no_we", bram_we, 0);
        if (h == 0 && v == 2) chk("count_held_over_blank", bram_addr, 1280);
      end
    end
    chk("we_pulse_count", we_cnt, N);
    chk("last_write_addr", last_we_addr, N - 1);
    chk("frame_done_count", done_cnt, 1);
    chk("frame_done_addr", done_addr, N - 1);
    chk("write_sequence_errors", bad, 0);
    chk("state_after_frame", bram_state, store_mid ? 2'b11 : 2'b00);
  endtask

  task automatic read_frame();
    int exp_addr = N - 1;
    int bad = 0;
    store_bram = 1'b1;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        drive(h, v, pix(h, v), 1'b0);
        if (h < H && v < V) exp_addr = v * H + h;
        if (bram_addr !== AW'(exp_addr) || bram_we !== 1'b0 || bram_state !== 2'b11) bad++;
        if (h == 10 && v == 2) chk("read_addr_10_2", bram_addr, 1290);
        if (h == 640 && v == 0) chk("read_addr_hold_blank", bram_addr, 639);
      end
    end
    chk("read_sequence_errors", bad, 0);
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0; store_bram = 1'b0;
    hcount = '0; vcount = '0; pixel_rgb = '0;
    step();
    step();
    chk("reset_state", bram_state, 0);
    chk("reset_addr", bram_addr, 0);
    chk("reset_we", bram_we, 0);
    chk("reset_din", bram_din, 0);
    chk("reset_done", frame_done, 0);
    reset = 1'b0;

    // Start a capture, then reset in the middle of writing.
    drive(700, 5, 24'h0, 1'b1);
    chk("idle_to_capture", bram_state, 2'b01);
    drive(0, 0, pix(0, 0), 1'b0);
    chk("sof_to_writing", bram_state, 2'b10);
    chk("sof_we", bram_we, 1);
    chk("sof_addr", bram_addr, 0);
    drive(1, 0, pix(1, 0), 1'b0);
    drive(2, 0, pix(2, 0), 1'b0);
    chk("early_write_addr", bram_addr, 2);
    reset = 1'b1;
    drive(3, 0, pix(3, 0), 1'b0);
    drive(4, 0, pix(4, 0), 1'b0);
    drive(5, 0, pix(5, 0), 1'b0);
    reset = 1'b0;
    chk("midwrite_reset_state", bram_state, 0);
    chk("midwrite_reset_we", bram_we, 0);
    chk("midwrite_reset_addr", bram_addr, 0);
    chk("midwrite_reset_done", frame_done, 0);
    drive(6, 0, pix(6, 0), 1'b0);
    chk("no_resume_state", bram_state, 0);
    chk("no_resume_we", bram_we, 0);

    // Capture off-screen, wait for sof, write a frame and keep it.
    drive(300, 200, pix(300, 200), 1'b1);
    chk("capture_at_300_200", bram_state, 2'b01);
    drive(301, 200, pix(301, 200), 1'b0);
    drive(302, 200, pix(302, 200), 1'b0);
    chk("wait_sof_state", bram_state, 2'b01);
    chk("wait_sof_we", bram_we, 0);
    write_frame(1'b1);

    read_frame();
    store_bram = 1'b0;
    drive(700, 5, 24'h0, 1'b0);
    chk("read_store_low_idle", bram_state, 2'b00);

    // Re-capture from READING_FRAME with store_bram dropping the same cycle.
    drive(700, 5, 24'h0, 1'b1);
    chk("idle_to_capture_2", bram_state, 2'b01);
    write_frame(1'b1);
    store_bram = 1'b0;
    drive(700, 5, 24'h0, 1'b1);
    chk("recapture_priority", bram_state, 2'b01);

    // store_bram falls mid-write: frame still completes, then IDLE.
    write_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
